// File: rtl/asic_output_classifier.sv
// asic_output_classifier
// Box-car averages the four XADC AUX channels (one per ASIC output neuron),
// picks the strongest channel above a threshold and only changes the
// reported classification after CONFIRM_COUNT identical window decisions.
// Optional peak-hold registers are built when CLASSIFIER_PEAK_HOLD_EN is defined.

module asic_output_classifier #(
    parameter int SAMPLE_WIDTH  = 12,
    parameter int AVG_LOG2      = 4,
    parameter int CONFIRM_COUNT = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sample_valid,
    input  logic [1:0]              sample_ch,
    input  logic [SAMPLE_WIDTH-1:0] sample_data,
    input  logic [SAMPLE_WIDTH-1:0] threshold,
    output logic [SAMPLE_WIDTH-1:0] avg_aux0,
    output logic [SAMPLE_WIDTH-1:0] avg_aux1,
    output logic [SAMPLE_WIDTH-1:0] avg_aux2,
    output logic [SAMPLE_WIDTH-1:0] avg_aux3,
    output logic [1:0]              network_output,
    output logic                    winner_valid,
    output logic                    decision_strobe,
    output logic [7:0]              drop_count,
    output logic [SAMPLE_WIDTH-1:0] peak_aux0,
    output logic [SAMPLE_WIDTH-1:0] peak_aux1,
    output logic [SAMPLE_WIDTH-1:0] peak_aux2,
    output logic [SAMPLE_WIDTH-1:0] peak_aux3,
    input  logic                    peak_clr
);

    localparam int               ACC_W       = SAMPLE_WIDTH + AVG_LOG2;
    localparam int               CNT_W       = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(2 ** AVG_LOG2);
    localparam logic [3:0]       CONFIRM_MAX = 4'(CONFIRM_COUNT);
    // Candidate encoding: bit 2 set means "no channel above threshold".
    localparam logic [2:0]       CAND_NONE   = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMP,
        ST_DECIDE
    } state_t;

    state_t                  state_q,      state_d;
    logic [1:0]              cmpIdx_q,     cmpIdx_d;
    logic [ACC_W-1:0]        acc_q [4];
    logic [ACC_W-1:0]        acc_d [4];
    logic [CNT_W-1:0]        cnt_q [4];
    logic [CNT_W-1:0]        cnt_d [4];
    logic [SAMPLE_WIDTH-1:0] avg_q [4];
    logic [SAMPLE_WIDTH-1:0] avg_d [4];
    logic [1:0]              bestIdx_q,    bestIdx_d;
    logic [SAMPLE_WIDTH-1:0] bestVal_q,    bestVal_d;
    logic [2:0]              prevCand_q,   prevCand_d;
    logic [3:0]              confirmCnt_q, confirmCnt_d;
    logic [1:0]              netOut_q,     netOut_d;
    logic                    winValid_q,   winValid_d;
    logic                    strobe_q,     strobe_d;
    logic [7:0]              drop_q,       drop_d;

    logic                    windowComplete;
    logic                    latchNow;
    logic [SAMPLE_WIDTH-1:0] newAvg [4];
    logic [2:0]              candidate;
    logic [3:0]              confirmNext;

    // Window status and the truncated averages that a latch would capture.
    always_comb begin
        windowComplete = 1'b1;
        for (int i = 0; i < 4; i++) begin
            newAvg[i] = acc_q[i][ACC_W-1:AVG_LOG2];
            if (cnt_q[i] != CNT_FULL) begin
                windowComplete = 1'b0;
            end
        end
    end

    assign latchNow = windowComplete && (state_q == ST_IDLE);

    // Accumulate samples, latch averages at window end and count discarded samples.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            acc_d[i] = acc_q[i];
            cnt_d[i] = cnt_q[i];
            avg_d[i] = avg_q[i];
        end
        drop_d = drop_q;
        if (latchNow) begin
            for (int i = 0; i < 4; i++) begin
                avg_d[i] = newAvg[i];
                acc_d[i] = '0;
                cnt_d[i] = '0;
            end
            if (sample_valid) begin
                acc_d[sample_ch] = ACC_W'(sample_data);
                cnt_d[sample_ch] = CNT_W'(1);
            end
        end else if (sample_valid) begin
            if (cnt_q[sample_ch] != CNT_FULL) begin
                acc_d[sample_ch] = acc_q[sample_ch] + ACC_W'(sample_data);
                cnt_d[sample_ch] = cnt_q[sample_ch] + CNT_W'(1);
            end else if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end
    end

    // Compare/decide sequencer: next state, running best channel and confirmation.
    always_comb begin
        state_d      = state_q;
        cmpIdx_d     = cmpIdx_q;
        bestIdx_d    = bestIdx_q;
        bestVal_d    = bestVal_q;
        prevCand_d   = prevCand_q;
        confirmCnt_d = confirmCnt_q;
        netOut_d     = netOut_q;
        winValid_d   = winValid_q;
        strobe_d     = 1'b0;
        candidate    = (bestVal_q >= threshold) ? {1'b0, bestIdx_q} : CAND_NONE;
        if (candidate == prevCand_q) begin
            confirmNext = (confirmCnt_q >= CONFIRM_MAX) ? CONFIRM_MAX : confirmCnt_q + 4'd1;
        end else begin
            confirmNext = 4'd1;
        end
        case (state_q)
            ST_IDLE: begin
                if (windowComplete) begin
                    state_d   = ST_CMP;
                    cmpIdx_d  = 2'd0;
                    bestIdx_d = 2'd0;
                    bestVal_d = newAvg[0];
                end
            end
            ST_CMP: begin
                if (avg_q[cmpIdx_q] > bestVal_q) begin
                    bestIdx_d = cmpIdx_q;
                    bestVal_d = avg_q[cmpIdx_q];
                end
                cmpIdx_d = cmpIdx_q + 2'd1;
                if (cmpIdx_q == 2'd3) begin
                    state_d = ST_DECIDE;
                end
            end
            ST_DECIDE: begin
                confirmCnt_d = confirmNext;
                prevCand_d   = candidate;
                if (confirmNext == CONFIRM_MAX) begin
                    if (candidate[2]) begin
                        winValid_d = 1'b0;
                    end else begin
                        netOut_d   = candidate[1:0];
                        winValid_d = 1'b1;
                    end
                end
                strobe_d = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register for the whole datapath; reset wins over every other event.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cmpIdx_q     <= '0;
            bestIdx_q    <= '0;
            bestVal_q    <= '0;
            prevCand_q   <= '0;
            confirmCnt_q <= '0;
            netOut_q     <= '0;
            winValid_q   <= 1'b0;
            strobe_q     <= 1'b0;
            drop_q       <= '0;
            for (int i = 0; i < 4; i++) begin
                acc_q[i] <= '0;
                cnt_q[i] <= '0;
                avg_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cmpIdx_q     <= cmpIdx_d;
            bestIdx_q    <= bestIdx_d;
            bestVal_q    <= bestVal_d;
            prevCand_q   <= prevCand_d;
            confirmCnt_q <= confirmCnt_d;
            netOut_q     <= netOut_d;
            winValid_q   <= winValid_d;
            strobe_q     <= strobe_d;
            drop_q       <= drop_d;
            for (int i = 0; i < 4; i++) begin
                acc_q[i] <= acc_d[i];
                cnt_q[i] <= cnt_d[i];
                avg_q[i] <= avg_d[i];
            end
        end
    end

    assign avg_aux0        = avg_q[0];
    assign avg_aux1        = avg_q[1];
    assign avg_aux2        = avg_q[2];
    assign avg_aux3        = avg_q[3];
    assign network_output  = netOut_q;
    assign winner_valid    = winValid_q;
    assign decision_strobe = strobe_q;
    assign drop_count      = drop_q;

`ifdef CLASSIFIER_PEAK_HOLD_EN
    logic [SAMPLE_WIDTH-1:0] peak_q [4];
    logic [SAMPLE_WIDTH-1:0] peak_d [4];

    // Track the largest window average per channel; a clear beats a same-cycle update.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            peak_d[i] = peak_q[i];
        end
        if (peak_clr) begin
            for (int i = 0; i < 4; i++) begin
                peak_d[i] = '0;
            end
        end else if (latchNow) begin
            for (int i = 0; i < 4; i++) begin
                if (newAvg[i] > peak_q[i]) begin
                    peak_d[i] = newAvg[i];
                end
            end
        end
    end

    // Peak-hold registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                peak_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                peak_q[i] <= peak_d[i];
            end
        end
    end

    assign peak_aux0 = peak_q[0];
    assign peak_aux1 = peak_q[1];
    assign peak_aux2 = peak_q[2];
    assign peak_aux3 = peak_q[3];
`else
    logic unusedPeakClr;
    assign unusedPeakClr = peak_clr;
    assign peak_aux0     = '0;
    assign peak_aux1     = '0;
    assign peak_aux2     = '0;
    assign peak_aux3     = '0;
`endif

endmodule

// File: tb/tb_asic_output_classifier.sv
// tb_asic_output_classifier
// Self-checking bench for asic_output_classifier. A behavioural model works on
// whole windows: per-channel sums of the first 2^AVG_LOG2 samples, an argmax
// with ties to the lower index, and a decision history where the output only
// moves once the last CONFIRM_COUNT decisions agree.

module tb_asic_output_classifier;

    localparam int SW         = 12;
    localparam int AVG_LOG2   = 4;
    localparam int CONFIRM    = 3;
    localparam int NSAMP      = 1 << AVG_LOG2;
    localparam int NONE       = 4;
    localparam int STROBE_LAT = 7;
    localparam int WAIT_MAX   = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          sample_valid;
    logic [1:0]    sample_ch;
    logic [SW-1:0] sample_data;
    logic [SW-1:0] threshold;
    logic [SW-1:0] avg_aux0, avg_aux1, avg_aux2, avg_aux3;
    logic [SW-1:0] peak_aux0, peak_aux1, peak_aux2, peak_aux3;
    logic [1:0]    network_output;
    logic          winner_valid;
    logic          decision_strobe;
    logic [7:0]    drop_count;
    logic          peak_clr;

    always #5 clk = ~clk;

    asic_output_classifier #(
        .SAMPLE_WIDTH  (SW),
        .AVG_LOG2      (AVG_LOG2),
        .CONFIRM_COUNT (CONFIRM)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .sample_valid    (sample_valid),
        .sample_ch       (sample_ch),
        .sample_data     (sample_data),
        .threshold       (threshold),
        .avg_aux0        (avg_aux0),
        .avg_aux1        (avg_aux1),
        .avg_aux2        (avg_aux2),
        .avg_aux3        (avg_aux3),
        .network_output  (network_output),
        .winner_valid    (winner_valid),
        .decision_strobe (decision_strobe),
        .drop_count      (drop_count),
        .peak_aux0       (peak_aux0),
        .peak_aux1       (peak_aux1),
        .peak_aux2       (peak_aux2),
        .peak_aux3       (peak_aux3),
        .peak_clr        (peak_clr)
    );

    logic [SW-1:0] avgOut  [4];
    logic [SW-1:0] peakOut [4];
    assign avgOut[0]  = avg_aux0;
    assign avgOut[1]  = avg_aux1;
    assign avgOut[2]  = avg_aux2;
    assign avgOut[3]  = avg_aux3;
    assign peakOut[0] = peak_aux0;
    assign peakOut[1] = peak_aux1;
    assign peakOut[2] = peak_aux2;
    assign peakOut[3] = peak_aux3;

    int testsRun    = 0;
    int testsFailed = 0;

    // Model state
    int            modelHist[$];
    logic [1:0]    expNet;
    logic          expValid;
    int            expDrops;
    logic [SW-1:0] expAvg  [4];
    logic [SW-1:0] expPeak [4];

    // Current window stimulus
    int            seqCh[$];
    logic [SW-1:0] seqData[$];
    logic [SW-1:0] lvl [4];
    int            noise;

    // Observations from the last played window
    logic [SW-1:0] obsAvg     [4];
    logic [SW-1:0] obsAvgEarly[4];
    logic [SW-1:0] obsPeak    [4];
    int            obsLat;
    int            obsStrobes;
    logic [1:0]    obsNet;
    logic          obsValid;
    logic [7:0]    obsDrop;

    task automatic modelReset();
        modelHist.delete();
        expNet   = 2'd0;
        expValid = 1'b0;
        expDrops = 0;
        for (int c = 0; c < 4; c++) begin
            expAvg[c]  = '0;
            expPeak[c] = '0;
        end
    endtask

    task automatic modelWindow();
        int sum[4];
        int cnt[4];
        int best;
        int cand;
        bit conf;
        for (int c = 0; c < 4; c++) begin
            sum[c] = 0;
            cnt[c] = 0;
        end
        for (int k = 0; k < seqCh.size(); k++) begin
            if (cnt[seqCh[k]] < NSAMP) begin
                sum[seqCh[k]] += int'(seqData[k]);
                cnt[seqCh[k]]++;
            end else if (expDrops < 255) begin
                expDrops++;
            end
        end
        for (int c = 0; c < 4; c++) expAvg[c] = SW'(sum[c] / NSAMP);
        best = 0;
        for (int c = 1; c < 4; c++) if (expAvg[c] > expAvg[best]) best = c;
        cand = (expAvg[best] >= threshold) ? best : NONE;
        modelHist.push_back(cand);
        conf = (modelHist.size() >= CONFIRM);
        for (int k = 0; k < CONFIRM && conf; k++) begin
            if (modelHist[modelHist.size() - 1 - k] != cand) conf = 1'b0;
        end
        if (conf) begin
            if (cand == NONE) begin
                expValid = 1'b0;
            end else begin
                expNet   = 2'(cand);
                expValid = 1'b1;
            end
        end
`ifdef CLASSIFIER_PEAK_HOLD_EN
        if (peak_clr !== 1'b1) begin
            for (int c = 0; c < 4; c++) if (expAvg[c] > expPeak[c]) expPeak[c] = expAvg[c];
        end
`endif
    endtask

    task automatic buildWindow(input bit shuffle);
        int rem[4];
        int c;
        int v;
        seqCh.delete();
        seqData.delete();
        for (int i = 0; i < 4; i++) rem[i] = NSAMP;
        for (int k = 0; k < 4 * NSAMP; k++) begin
            if (shuffle) begin
                c = int'($urandom_range(0, 3));
                while (rem[c] == 0) c = (c + 1) % 4;
            end else begin
                c = k % 4;
            end
            rem[c]--;
            v = int'(lvl[c]);
            if (noise > 0) v += int'($urandom_range(0, noise));
            if (v > 4095) v = 4095;
            seqCh.push_back(c);
            seqData.push_back(SW'(v));
        end
    endtask

    task automatic playWindow();
        for (int k = 0; k < seqCh.size(); k++) begin
            @(negedge clk);
            sample_valid = 1'b1;
            sample_ch    = 2'(seqCh[k]);
            sample_data  = seqData[k];
        end
        obsLat     = -1;
        obsStrobes = 0;
        obsNet     = 2'bxx;
        obsValid   = 1'bx;
        for (int t = 1; t <= WAIT_MAX; t++) begin
            @(negedge clk);
            sample_valid = 1'b0;
            if (t == 1) for (int c = 0; c < 4; c++) obsAvgEarly[c] = avgOut[c];
            if (t == 2) for (int c = 0; c < 4; c++) obsAvg[c] = avgOut[c];
            if (decision_strobe === 1'b1) begin
                obsStrobes++;
                if (obsLat < 0) begin
                    obsLat   = t;
                    obsNet   = network_output;
                    obsValid = winner_valid;
                end
            end
        end
        for (int c = 0; c < 4; c++) obsPeak[c] = peakOut[c];
        obsDrop = drop_count;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        sample_valid = 1'b0;
        sample_ch    = 2'd0;
        sample_data  = '0;
        threshold    = 12'h200;
        peak_clr     = 1'b0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) begin
                testsRun++;
                if (avgOut[c] !== '0 || peakOut[c] !== '0) begin
                    testsFailed++;
                    $display("[TB] FAIL reset_avg_peak%0d: got avg %h peak %h, expected 0", c, avgOut[c], peakOut[c]);
                end
            end
            testsRun++;
            if ({network_output, winner_valid, decision_strobe} !== 4'b0000 || drop_count !== 8'd0) begin
                testsFailed++;
                $display("[TB] FAIL reset_ctrl: got net %h valid %b strobe %b drops %0d, expected all 0", network_output, winner_valid, decision_strobe, drop_count);
            end
            sample_valid = ~sample_valid;
            sample_ch    = 2'($urandom_range(0, 3));
            sample_data  = SW'($urandom);
        end
        @(negedge clk);
        rst          = 1'b0;
        sample_valid = 1'b0;
        modelReset();
    endtask

    task automatic test_winner();
        logic [SW-1:0] prevAvg[4];
        threshold = 12'h200;
        noise     = 0;
        lvl[0] = 12'h100; lvl[1] = 12'h100; lvl[2] = 12'h800; lvl[3] = 12'h100;
        for (int w = 0; w < 3; w++) begin
            for (int c = 0; c < 4; c++) prevAvg[c] = expAvg[c];
            buildWindow(1'b0);
            modelWindow();
            playWindow();
            for (int c = 0; c < 4; c++) begin
                testsRun++;
                if (obsAvgEarly[c] !== prevAvg[c] || obsAvg[c] !== expAvg[c]) begin
                    testsFailed++;
                    $display("[TB] FAIL winner_avg%0d_w%0d: got %h then %h, expected %h then %h", c, w, obsAvgEarly[c], obsAvg[c], prevAvg[c], expAvg[c]);
                end
            end
            testsRun++;
            if (obsLat !== STROBE_LAT || obsStrobes !== 1) begin
                testsFailed++;
                $display("[TB] FAIL winner_strobe_w%0d: got latency %0d count %0d, expected %0d and 1", w, obsLat, obsStrobes, STROBE_LAT);
            end
            testsRun++;
            if (obsNet !== expNet || obsValid !== expValid) begin
                testsFailed++;
                $display("[TB] FAIL winner_out_w%0d: got net %h valid %b, expected net %h valid %b", w, obsNet, obsValid, expNet, expValid);
            end
        end
    endtask

    task automatic test_below_threshold();
        threshold = 12'h200;
        noise     = 0;
        for (int c = 0; c < 4; c++) lvl[c] = 12'h100;
        for (int w = 0; w < 3; w++) begin
            buildWindow(1'b0);
            modelWindow();
            playWindow();
            testsRun++;
            if (obsNet !== expNet || obsValid !== expValid) begin
                testsFailed++;
                $display("[TB] FAIL below_thr_out_w%0d: got net %h valid %b, expected net %h valid %b", w, obsNet, obsValid, expNet, expValid);
            end
            testsRun++;
            if (obsLat !== STROBE_LAT) begin
                testsFailed++;
                $display("[TB] FAIL below_thr_latency_w%0d: got %0d, expected %0d", w, obsLat, STROBE_LAT);
            end
        end
    endtask

    task automatic test_tie();
        threshold = 12'h200;
        noise     = 0;
        lvl[0] = 12'h050; lvl[1] = 12'h600; lvl[2] = 12'h050; lvl[3] = 12'h600;
        for (int w = 0; w < 3; w++) begin
            buildWindow(1'b1);
            modelWindow();
            playWindow();
            testsRun++;
            if (obsNet !== expNet || obsValid !== expValid) begin
                testsFailed++;
                $display("[TB] FAIL tie_out_w%0d: got net %h valid %b, expected net %h valid %b", w, obsNet, obsValid, expNet, expValid);
            end
            testsRun++;
            if (obsAvg[1] !== expAvg[1] || obsAvg[3] !== expAvg[3]) begin
                testsFailed++;
                $display("[TB] FAIL tie_avg_w%0d: got %h/%h, expected %h/%h", w, obsAvg[1], obsAvg[3], expAvg[1], expAvg[3]);
            end
        end
    endtask

    task automatic test_drops();
        seqCh.delete();
        seqData.delete();
        for (int k = 0; k < NSAMP + 4; k++) begin
            seqCh.push_back(0);
            seqData.push_back(SW'($urandom_range(0, 4095)));
        end
        for (int k = 0; k < NSAMP; k++) begin
            for (int c = 1; c < 4; c++) begin
                seqCh.push_back(c);
                seqData.push_back(SW'($urandom_range(0, 4095)));
            end
        end
        modelWindow();
        playWindow();
        for (int c = 0; c < 4; c++) begin
            testsRun++;
            if (obsAvg[c] !== expAvg[c]) begin
                testsFailed++;
                $display("[TB] FAIL drops_avg%0d: got %h, expected %h", c, obsAvg[c], expAvg[c]);
            end
        end
        testsRun++;
        if (obsDrop !== 8'(expDrops)) begin
            testsFailed++;
            $display("[TB] FAIL drops_count: got %0d, expected %0d", obsDrop, expDrops);
        end
        testsRun++;
        if (obsStrobes !== 1 || obsNet !== expNet || obsValid !== expValid) begin
            testsFailed++;
            $display("[TB] FAIL drops_decision: got strobes %0d net %h valid %b, expected 1 net %h valid %b", obsStrobes, obsNet, obsValid, expNet, expValid);
        end
    endtask

    task automatic test_back_to_back();
        int            streamCh[$];
        logic [SW-1:0] streamData[$];
        logic [SW-1:0] expWinAvg[3][4];
        logic [SW-1:0] obsWinAvg[3][4];
        int            strobes;
        int            total;
        threshold = 12'h300;
        noise     = 32;
        lvl[0] = 12'h400; lvl[1] = 12'h200; lvl[2] = 12'h100; lvl[3] = 12'h380;
        for (int w = 0; w < 3; w++) begin
            buildWindow(1'b0);
            modelWindow();
            for (int c = 0; c < 4; c++) expWinAvg[w][c] = expAvg[c];
            for (int k = 0; k < seqCh.size(); k++) begin
                streamCh.push_back(seqCh[k]);
                streamData.push_back(seqData[k]);
            end
        end
        strobes = 0;
        total   = streamCh.size();
        for (int k = 0; k < total + WAIT_MAX; k++) begin
            @(negedge clk);
            if (k >= 2 && ((k - 2) % (4 * NSAMP)) == (4 * NSAMP - 1)) begin
                for (int c = 0; c < 4; c++) obsWinAvg[(k - 2) / (4 * NSAMP)][c] = avgOut[c];
            end
            if (decision_strobe === 1'b1) strobes++;
            if (k < total) begin
                sample_valid = 1'b1;
                sample_ch    = 2'(streamCh[k]);
                sample_data  = streamData[k];
            end else begin
                sample_valid = 1'b0;
            end
        end
        for (int w = 0; w < 3; w++) begin
            for (int c = 0; c < 4; c++) begin
                testsRun++;
                if (obsWinAvg[w][c] !== expWinAvg[w][c]) begin
                    testsFailed++;
                    $display("[TB] FAIL b2b_avg%0d_w%0d: got %h, expected %h", c, w, obsWinAvg[w][c], expWinAvg[w][c]);
                end
            end
        end
        testsRun++;
        if (strobes !== 3 || drop_count !== 8'(expDrops)) begin
            testsFailed++;
            $display("[TB] FAIL b2b_strobes_drops: got %0d strobes %0d drops, expected 3 strobes %0d drops", strobes, drop_count, expDrops);
        end
        testsRun++;
        if (network_output !== expNet || winner_valid !== expValid) begin
            testsFailed++;
            $display("[TB] FAIL b2b_out: got net %h valid %b, expected net %h valid %b", network_output, winner_valid, expNet, expValid);
        end
    endtask

    task automatic test_random();
        int fav;
        fav   = int'($urandom_range(0, 3));
        noise = 63;
        for (int w = 0; w < 8; w++) begin
            if ($urandom_range(0, 1) == 1) fav = int'($urandom_range(0, 3));
            threshold = SW'($urandom_range(0, 12'hA00));
            for (int c = 0; c < 4; c++) begin
                lvl[c] = (c == fav) ? SW'($urandom_range(12'h900, 12'hFC0)) : SW'($urandom_range(0, 12'h8FF));
            end
            buildWindow(1'b1);
            modelWindow();
            playWindow();
            for (int c = 0; c < 4; c++) begin
                testsRun++;
                if (obsAvg[c] !== expAvg[c] || obsPeak[c] !== expPeak[c]) begin
                    testsFailed++;
                    $display("[TB] FAIL rand_avg_peak%0d_w%0d: got %h/%h, expected %h/%h", c, w, obsAvg[c], obsPeak[c], expAvg[c], expPeak[c]);
                end
            end
            testsRun++;
            if (obsLat !== STROBE_LAT || obsNet !== expNet || obsValid !== expValid) begin
                testsFailed++;
                $display("[TB] FAIL rand_decision_w%0d: got lat %0d net %h valid %b, expected lat %0d net %h valid %b", w, obsLat, obsNet, obsValid, STROBE_LAT, expNet, expValid);
            end
        end
    endtask

    task automatic test_mid_reset();
        for (int k = 0; k < 8 * 4; k++) begin
            @(negedge clk);
            sample_valid = 1'b1;
            sample_ch    = 2'(k % 4);
            sample_data  = SW'($urandom_range(12'hC00, 12'hFFF));
        end
        @(negedge clk);
        sample_valid = 1'b0;
        rst          = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        modelReset();
        testsRun++;
        if (drop_count !== 8'd0 || winner_valid !== 1'b0 || network_output !== 2'd0) begin
            testsFailed++;
            $display("[TB] FAIL midrst_clear: got drops %0d valid %b net %h, expected 0", drop_count, winner_valid, network_output);
        end
        threshold = 12'h200;
        noise     = 0;
        for (int c = 0; c < 4; c++) lvl[c] = 12'h300;
        buildWindow(1'b0);
        modelWindow();
        playWindow();
        for (int c = 0; c < 4; c++) begin
            testsRun++;
            if (obsAvg[c] !== expAvg[c] || obsPeak[c] !== expPeak[c]) begin
                testsFailed++;
                $display("[TB] FAIL midrst_avg_peak%0d: got %h/%h, expected %h/%h", c, obsAvg[c], obsPeak[c], expAvg[c], expPeak[c]);
            end
        end
        @(negedge clk);
        peak_clr = 1'b1;
        @(negedge clk);
        peak_clr = 1'b0;
        for (int c = 0; c < 4; c++) expPeak[c] = '0;
        for (int c = 0; c < 4; c++) begin
            testsRun++;
            if (peakOut[c] !== expPeak[c]) begin
                testsFailed++;
                $display("[TB] FAIL peak_clr%0d: got %h, expected %h", c, peakOut[c], expPeak[c]);
            end
        end
        peak_clr = 1'b1;
        for (int c = 0; c < 4; c++) lvl[c] = 12'h700;
        buildWindow(1'b0);
        modelWindow();
        playWindow();
        peak_clr = 1'b0;
        for (int c = 0; c < 4; c++) begin
            testsRun++;
            if (obsPeak[c] !== expPeak[c] || obsAvg[c] !== expAvg[c]) begin
                testsFailed++;
                $display("[TB] FAIL peak_clr_priority%0d: got peak %h avg %h, expected peak %h avg %h", c, obsPeak[c], obsAvg[c], expPeak[c], expAvg[c]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_winner();
        test_below_threshold();
        test_tie();
        test_drops();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
